operand_fetch_stage: RTL
========================

Name: operand_fetch_stage

Overview:
- Pipeline stage directly downstream of regFile16b16.
- Drives the register-file read addresses from the decoded instruction and captures ReadDataA/ReadDataB/ReadDataCR into an operand register for the execute stage.
- Resolves write-back hazards by forwarding and by snooping writes into held entries.
- Uses a valid/ready handshake with a 2-entry (output + skid) buffer so the execute stage can stall without data loss.

Parameters:
- DATA_W, 16, operand/data width (matches register file)
- ADDR_W, 4, register address width (16 registers)
- OP_W, 4, opcode field width carried through

Ports:
- CLK  in  1  clock, all state updates on rising edge
- Reset_n  in  1  asynchronous active-low reset
- Flush  in  1  synchronous; discards all held entries
- InValid  in  1  decode presents an instruction
- InReady  out  1  stage can accept an instruction this cycle
- InRs  in  ADDR_W  source A register
- InRt  in  ADDR_W  source B register
- InRd  in  ADDR_W  destination register, passed through
- InOp  in  OP_W  opcode, passed through
- ReadAddrA  out  ADDR_W  to register file, equals InRs (combinational)
- ReadAddrB  out  ADDR_W  to register file, equals InRt (combinational)
- ReadDataA  in  DATA_W  from register file
- ReadDataB  in  DATA_W  from register file
- ReadDataCR  in  DATA_W  control register from register file
- WbWrite  in  1  write-back strobe (same signal as the register file Write)
- WbAddr  in  ADDR_W  write-back address
- WbData  in  DATA_W  write-back data
- OutValid  out  1  operand bundle valid
- OutReady  in  1  execute stage accepts
- OutOpA  out  DATA_W  operand A
- OutOpB  out  DATA_W  operand B
- OutCR  out  DATA_W  captured control register
- OutRd  out  ADDR_W  destination register
- OutOpc  out  OP_W  opcode
- StallCount  out  16  see Optional Feature

Behaviour:
- Reset (async, Reset_n=0):
  - OutValid=0, skid valid=0, InReady=1.
  - OutOpA/OutOpB/OutCR=0, OutRd=0, OutOpc=0, StallCount=0.
  - Reset mid-transfer discards all entries.
- InReady is registered and equals !skid_valid.
  - A transfer in occurs when InValid && InReady.
  - A transfer out occurs when OutValid && OutReady.
- Capture forwarding (register file writes on the rising edge, so a same-cycle read returns the old value):
  - A = (WbWrite && WbAddr==InRs) ? WbData : ReadDataA.
  - B is the same with InRt / ReadDataB.
  - No special case for address 0.
- Snoop: every cycle, for each valid held entry (output and skid):
  - If WbWrite && WbAddr==entry.Rs, then entry.OpA<=WbData.
  - If WbWrite && WbAddr==entry.Rt, then entry.OpB<=WbData.
  - Entries therefore hold InRs/InRt internally.
  - The snoop applies even when the entry is transferring out that same cycle; it is harmless.
- Buffer states: EMPTY (out=0, skid=0), ONE (out=1, skid=0), FULL (out=1, skid=1).
  - EMPTY + in → ONE; capture goes to the output register.
  - ONE + in + out → ONE; the output register is reloaded with the new capture.
  - ONE + in, no out → FULL; capture goes to skid, InReady falls next cycle.
  - ONE + out, no in → EMPTY.
  - FULL + out → ONE; skid moves to output, InReady rises next cycle. No input is possible since InReady=0.
  - FULL, no out → FULL; outputs held stable except snoop updates.
- Ordering: strictly in order, and the skid entry is always younger than the output entry.
- Flush: next edge forces EMPTY and InReady=1. Flush has priority over a simultaneous transfer in or out (the incoming instruction is dropped).
- Latency: 1 cycle from accepted input to OutValid when EMPTY. Throughput is 1 per cycle while OutReady=1.
- OutCR is sampled from ReadDataCR at capture and is not snooped.

Optional Feature:
- Macro OPFETCH_STALL_COUNT_EN.
- Defined:
  - StallCount increments each cycle with OutValid && !OutReady.
  - Saturates at 16'hFFFF.
  - Cleared by reset or Flush.
- Undefined: StallCount is tied to 16'h0000 and the counter logic is absent.

Test Plan:
- Reset then an idle cycle → OutValid=0, InReady=1, all outputs 0. Assert Reset_n low while FULL → immediate EMPTY, InReady=1.
- Regfile r3=0x0003, r5=0x0005. Present Rs=3, Rt=5, Rd=7, OutReady=1 → next cycle OutOpA=0x0003, OutOpB=0x0005, OutRd=7, OutValid=1 for exactly 1 cycle.
- Same-cycle forward: WbWrite=1, WbAddr=3, WbData=0x1234, with InRs=3 captured → OutOpA=0x1234, not the old 0x0003.
- Stall/snoop: OutReady=0, issue two instructions both reading r4 (old 0x0004) → InReady=0 after the second. Then WbWrite r4=0xBEEF. Raise OutReady → both bundles emerge in order with OpA=0xBEEF, and InReady returns to 1.
- Flush while FULL with InValid=1 → next cycle OutValid=0, InReady=1, and the incoming instruction never appears.
- With OPFETCH_STALL_COUNT_EN: hold OutValid=1, OutReady=0 for 10 cycles → StallCount=10; Flush → 0. Without the macro → StallCount stays 0.

Source files
------------

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: sits directly behind the 16x16 register file.
// Drives the read addresses from the decoded instruction, captures the operands
// (with write-back forwarding) into a 2-entry output/skid buffer, and keeps the
// held operands current by snooping write-backs.
// Optional build macro: OPFETCH_STALL_COUNT_EN enables the StallCount counter;
// when it is undefined StallCount is tied to zero.
module operand_fetch_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int OP_W   = 4
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              Flush,
  input  logic              InValid,
  output logic              InReady,
  input  logic [ADDR_W-1:0] InRs,
  input  logic [ADDR_W-1:0] InRt,
  input  logic [ADDR_W-1:0] InRd,
  input  logic [OP_W-1:0]   InOp,
  output logic [ADDR_W-1:0] ReadAddrA,
  output logic [ADDR_W-1:0] ReadAddrB,
  input  logic [DATA_W-1:0] ReadDataA,
  input  logic [DATA_W-1:0] ReadDataB,
  input  logic [DATA_W-1:0] ReadDataCR,
  input  logic              WbWrite,
  input  logic [ADDR_W-1:0] WbAddr,
  input  logic [DATA_W-1:0] WbData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] OutOpA,
  output logic [DATA_W-1:0] OutOpB,
  output logic [DATA_W-1:0] OutCR,
  output logic [ADDR_W-1:0] OutRd,
  output logic [OP_W-1:0]   OutOpc,
  output logic [15:0]       StallCount
);

  // Buffer occupancy: out only = ONE, out + skid = FULL.
  logic              r_out_valid;
  logic              r_skid_valid;
  logic              r_in_ready;

  // Output entry (source addresses kept so the entry can be snooped).
  logic [DATA_W-1:0] r_out_a, r_out_b, r_out_cr;
  logic [ADDR_W-1:0] r_out_rs, r_out_rt, r_out_rd;
  logic [OP_W-1:0]   r_out_opc;

  // Skid entry, always younger than the output entry.
  logic [DATA_W-1:0] r_skid_a, r_skid_b, r_skid_cr;
  logic [ADDR_W-1:0] r_skid_rs, r_skid_rt, r_skid_rd;
  logic [OP_W-1:0]   r_skid_opc;

  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_load_out_cap;
  logic              w_load_out_skid;
  logic              w_load_skid;
  logic              w_skid_valid_next;
  logic [DATA_W-1:0] w_cap_a, w_cap_b;
  logic [DATA_W-1:0] w_out_a_snp, w_out_b_snp;
  logic [DATA_W-1:0] w_skid_a_snp, w_skid_b_snp;

  assign ReadAddrA = InRs;
  assign ReadAddrB = InRt;

  assign w_in_fire  = InValid && r_in_ready;
  assign w_out_fire = r_out_valid && OutReady;

  // The register file writes on the same edge we capture, so its read data is
  // stale for a matching write-back; forward WbData instead.
  assign w_cap_a = (WbWrite && (WbAddr == InRs)) ? WbData : ReadDataA;
  assign w_cap_b = (WbWrite && (WbAddr == InRt)) ? WbData : ReadDataB;

  // Snooped views of the held entries (snooping an empty slot is harmless).
  assign w_out_a_snp  = (WbWrite && (WbAddr == r_out_rs))  ? WbData : r_out_a;
  assign w_out_b_snp  = (WbWrite && (WbAddr == r_out_rt))  ? WbData : r_out_b;
  assign w_skid_a_snp = (WbWrite && (WbAddr == r_skid_rs)) ? WbData : r_skid_a;
  assign w_skid_b_snp = (WbWrite && (WbAddr == r_skid_rt)) ? WbData : r_skid_b;

  // Capture lands in the output slot when it is empty or draining this cycle;
  // otherwise it parks in the skid slot. A FULL buffer never accepts input.
  assign w_load_out_cap    = w_in_fire && (!r_out_valid || w_out_fire);
  assign w_load_skid       = w_in_fire && r_out_valid && !w_out_fire;
  assign w_load_out_skid   = r_skid_valid && w_out_fire;
  assign w_skid_valid_next = w_load_skid || (r_skid_valid && !w_out_fire);

  // Occupancy and registered ready; Flush overrides any transfer.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (Flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else begin
      r_out_valid  <= w_in_fire || r_skid_valid || (r_out_valid && !OutReady);
      r_skid_valid <= w_skid_valid_next;
      r_in_ready   <= !w_skid_valid_next;
    end
  end

  // Entry payloads: snoop every cycle, then overlay any load.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_out_a    <= '0;
      r_out_b    <= '0;
      r_out_cr   <= '0;
      r_out_rs   <= '0;
      r_out_rt   <= '0;
      r_out_rd   <= '0;
      r_out_opc  <= '0;
      r_skid_a   <= '0;
      r_skid_b   <= '0;
      r_skid_cr  <= '0;
      r_skid_rs  <= '0;
      r_skid_rt  <= '0;
      r_skid_rd  <= '0;
      r_skid_opc <= '0;
    end else begin
      r_out_a  <= w_out_a_snp;
      r_out_b  <= w_out_b_snp;
      r_skid_a <= w_skid_a_snp;
      r_skid_b <= w_skid_b_snp;
      if (!Flush) begin
        if (w_load_out_cap) begin
          r_out_a   <= w_cap_a;
          r_out_b   <= w_cap_b;
          r_out_cr  <= ReadDataCR;
          r_out_rs  <= InRs;
          r_out_rt  <= InRt;
          r_out_rd  <= InRd;
          r_out_opc <= InOp;
        end else if (w_load_out_skid) begin
          r_out_a   <= w_skid_a_snp;
          r_out_b   <= w_skid_b_snp;
          r_out_cr  <= r_skid_cr;
          r_out_rs  <= r_skid_rs;
          r_out_rt  <= r_skid_rt;
          r_out_rd  <= r_skid_rd;
          r_out_opc <= r_skid_opc;
        end
        if (w_load_skid) begin
          r_skid_a   <= w_cap_a;
          r_skid_b   <= w_cap_b;
          r_skid_cr  <= ReadDataCR;
          r_skid_rs  <= InRs;
          r_skid_rt  <= InRt;
          r_skid_rd  <= InRd;
          r_skid_opc <= InOp;
        end
      end
    end
  end

  assign InReady  = r_in_ready;
  assign OutValid = r_out_valid;
  assign OutOpA   = r_out_a;
  assign OutOpB   = r_out_b;
  assign OutCR    = r_out_cr;
  assign OutRd    = r_out_rd;
  assign OutOpc   = r_out_opc;

`ifdef OPFETCH_STALL_COUNT_EN
  logic [15:0] r_stall_cnt;

  // Count cycles where a bundle is offered but execute is not taking it.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_stall_cnt <= 16'h0000;
    end else if (Flush) begin
      r_stall_cnt <= 16'h0000;
    end else if (r_out_valid && !OutReady && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'h0001;
    end
  end

  assign StallCount = r_stall_cnt;
`else
  assign StallCount = 16'h0000;
`endif

endmodule
